// File: rtl/counter_nbit_ctl_if.sv
// Control/status bundle for counter_nbit_ctl: the controller drives the master side,
// and the counter drives the slave side.
interface counter_nbit_ctl_if #(
    parameter int WIDTH = 8
);
    logic             i_en;
    logic             i_clear;
    logic             i_load;
    logic [WIDTH-1:0] i_load_value;
    logic             i_down;
    logic             i_ovf_clr;
    logic [WIDTH-1:0] o_count;
    logic             o_at_limit;
    logic             o_tc;
    logic             o_overflow;

    modport master (
        output i_en, i_clear, i_load, i_load_value, i_down, i_ovf_clr,
        input  o_count, o_at_limit, o_tc, o_overflow
    );

    modport slave (
        input  i_en, i_clear, i_load, i_load_value, i_down, i_ovf_clr,
        output o_count, o_at_limit, o_tc, o_overflow
    );
endinterface

// File: rtl/counter_nbit_ctl.sv
// Parametrised up/down counter with modulus, wrap/saturate, enable prescaler,
// synchronous clear/load and terminal-count / sticky overflow flags.
module counter_nbit_ctl #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 2**WIDTH - 1,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    counter_nbit_ctl_if.slave  bus
);
    localparam int              PreWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0]    MaxCount = WIDTH'(MAX_VALUE);
    localparam logic [PreWidth-1:0] PreLast  = PreWidth'(PRESCALE - 1);
    localparam bit                  SatMode  = (SATURATE != 0);

    logic [WIDTH-1:0]    count_q, count_d;
    logic [PreWidth-1:0] pre_q, pre_d;
    logic                tc_q, tc_d;
    logic                ovf_q, ovf_d;
    logic                step;
    logic                limitHit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Priority is clear > load > step; a limit event's overflow set beats ovf_clr.
    always_comb begin
        count_d  = count_q;
        pre_d    = pre_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q;
        step     = 1'b0;
        limitHit = 1'b0;

        if (bus.i_clear) begin
            count_d = '0;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (bus.i_load) begin
            count_d = (bus.i_load_value > MaxCount) ? MaxCount : bus.i_load_value;
            pre_d   = '0;
            if (bus.i_ovf_clr) ovf_d = 1'b0;
        end else begin
            if (bus.i_ovf_clr) ovf_d = 1'b0;

            if (bus.i_en) begin
                if (pre_q == PreLast) begin
                    pre_d = '0;
                    step  = 1'b1;
                end else begin
                    pre_d = pre_q + PreWidth'(1);
                end
            end

            if (step) begin
                if (!bus.i_down) begin
                    if (count_q == MaxCount) begin
                        limitHit = 1'b1;
                        count_d  = SatMode ? MaxCount : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        limitHit = 1'b1;
                        count_d  = SatMode ? '0 : MaxCount;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end

            if (limitHit) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end
    end

    assign bus.o_count    = count_q;
    assign bus.o_tc       = tc_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_at_limit = ((count_q == MaxCount) && !bus.i_down) ||
                            ((count_q == '0) && bus.i_down);
endmodule

// File: tb/tb_counter_nbit_ctl.sv
// Scoreboard bench for counter_nbit_ctl: three instances (wrap, saturate, prescale-by-3),
// all WIDTH=4 with MAX_VALUE=9.
module tb_counter_nbit_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    counter_nbit_ctl_if #(.WIDTH(4)) ifW ();
    counter_nbit_ctl_if #(.WIDTH(4)) ifS ();
    counter_nbit_ctl_if #(.WIDTH(4)) ifP ();

    counter_nbit_ctl #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(0)) dutW (
        .i_clk(clk), .i_reset(rst), .bus(ifW.slave));
    counter_nbit_ctl #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1)) dutS (
        .i_clk(clk), .i_reset(rst), .bus(ifS.slave));
    counter_nbit_ctl #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(0)) dutP (
        .i_clk(clk), .i_reset(rst), .bus(ifP.slave));

    typedef struct {
        string    tag;
        logic [5:0] v;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Expected {count, tc, overflow} after the next rising edge.
    task automatic pushExp(input string tag, input logic [3:0] c, input logic tc, input logic ovf);
        exp_t e;
        e.tag = tag;
        e.v   = {c, tc, ovf};
        sbq.push_back(e);
    endtask

    task automatic idleAll();
        ifW.i_en = 0; ifW.i_clear = 0; ifW.i_load = 0; ifW.i_load_value = '0; ifW.i_down = 0; ifW.i_ovf_clr = 0;
        ifS.i_en = 0; ifS.i_clear = 0; ifS.i_load = 0; ifS.i_load_value = '0; ifS.i_down = 0; ifS.i_ovf_clr = 0;
        ifP.i_en = 0; ifP.i_clear = 0; ifP.i_load = 0; ifP.i_load_value = '0; ifP.i_down = 0; ifP.i_ovf_clr = 0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        idleAll();
        repeat (2) @(posedge clk);
        #1;
        got = {ifW.o_count, ifW.o_tc, ifW.o_overflow} | {ifS.o_count, ifS.o_tc, ifS.o_overflow}
            | {ifP.o_count, ifP.o_tc, ifP.o_overflow};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got OR of {count,tc,ovf}=%b, expected 000000", got);
        end
        checks++;
        if (ifW.o_at_limit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_at_limit: got %b, expected 0", ifW.o_at_limit);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        exp_t e;
        logic [5:0] got;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ifW.i_en = 1; ifW.i_down = 0;
            checks++;
            if (ifW.o_at_limit !== (((k - 1) % 10) == 9)) begin
                errors++;
                $display("[TB] FAIL wrap_at_limit k=%0d: got %b, expected %b", k, ifW.o_at_limit, ((k - 1) % 10) == 9);
            end
            pushExp($sformatf("wrap_up k=%0d", k), 4'(k % 10), k == 10, k >= 10);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
        end
        @(negedge clk);
        ifW.i_en = 0;
    endtask

    task automatic test_load_down();
        exp_t e;
        logic [5:0] got;
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            if (j == 0) begin
                ifW.i_load = 1; ifW.i_load_value = 4'd3; ifW.i_en = 1; ifW.i_down = 1;
                pushExp("load3", 4'd3, 1'b0, 1'b1);
            end else begin
                ifW.i_load = 0;
                checks++;
                if (ifW.o_at_limit !== (j == 4)) begin
                    errors++;
                    $display("[TB] FAIL down_at_limit j=%0d: got %b, expected %b", j, ifW.o_at_limit, j == 4);
                end
                pushExp($sformatf("down j=%0d", j), 4'((13 - j) % 10), j == 4, 1'b1);
            end
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
        end
        @(negedge clk);
        ifW.i_en = 0;
        #1;
        checks++;
        if (ifW.o_at_limit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL at_limit_9_down: got %b, expected 0", ifW.o_at_limit);
        end
        ifW.i_down = 0;
        #1;
        checks++;
        if (ifW.o_at_limit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL at_limit_9_up: got %b, expected 1", ifW.o_at_limit);
        end
        ifW.i_ovf_clr = 1;
        pushExp("ovf_clr_idle", 4'd9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
        checks++;
        if (got !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                     e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
        end
        @(negedge clk);
        ifW.i_ovf_clr = 0;
    endtask

    task automatic test_load_clamp();
        exp_t e;
        logic [5:0] got;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            case (j)
                0: begin
                    ifW.i_load = 1; ifW.i_load_value = 4'd15; ifW.i_en = 0;
                    pushExp("load15_clamp", 4'd9, 1'b0, 1'b0);
                end
                1: begin
                    ifW.i_load = 0; ifW.i_en = 1; ifW.i_down = 0;
                    pushExp("clamp_then_wrap", 4'd0, 1'b1, 1'b1);
                end
                default: begin
                    ifW.i_clear = 1; ifW.i_load = 1; ifW.i_load_value = 4'd5; ifW.i_en = 1;
                    pushExp("clear_beats_load", 4'd0, 1'b0, 1'b0);
                end
            endcase
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
        end
        @(negedge clk);
        ifW.i_clear = 0; ifW.i_load = 0; ifW.i_en = 0;
    endtask

    task automatic test_saturate();
        exp_t e;
        logic [5:0] got;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                ifS.i_en = 1; ifS.i_down = 0;
                pushExp($sformatf("sat_up k=%0d", k), (k > 9) ? 4'd9 : 4'(k), k >= 10, k >= 10);
            end else if (k == 13) begin
                ifS.i_ovf_clr = 1;
                pushExp("sat_ovfclr_vs_limit", 4'd9, 1'b1, 1'b1);
            end else if (k == 14) begin
                ifS.i_en = 0;
                pushExp("sat_ovfclr_idle", 4'd9, 1'b0, 1'b0);
            end else if (k == 15) begin
                ifS.i_ovf_clr = 0; ifS.i_load = 1; ifS.i_load_value = 4'd0;
                pushExp("sat_load0", 4'd0, 1'b0, 1'b0);
            end else begin
                ifS.i_load = 0; ifS.i_en = 1; ifS.i_down = 1;
                pushExp("sat_down_hold0", 4'd0, 1'b1, 1'b1);
            end
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifS.o_count, ifS.o_tc, ifS.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
        end
        @(negedge clk);
        ifS.i_en = 0; ifS.i_down = 0;
    endtask

    task automatic test_prescale();
        exp_t e;
        logic [5:0] got;
        logic [10:0] pattern;
        int enabled;
        pattern = 11'b11111_00_1111;
        enabled = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ifP.i_en = pattern[k]; ifP.i_down = 0;
            if (pattern[k]) enabled++;
            pushExp($sformatf("prescale k=%0d", k), 4'(enabled / 3), 1'b0, 1'b0);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifP.o_count, ifP.o_tc, ifP.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
        end
        @(negedge clk);
        ifP.i_en = 0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [5:0] got;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            ifW.i_down = 0;
            case (j)
                0: begin ifW.i_load = 1; ifW.i_load_value = 4'd9; ifW.i_en = 0; pushExp("mid_load9", 4'd9, 1'b0, 1'b0); end
                1: begin ifW.i_load = 0; ifW.i_en = 1; pushExp("mid_wrap", 4'd0, 1'b1, 1'b1); end
                2: begin ifW.i_load = 1; ifW.i_load_value = 4'd4; pushExp("mid_load4", 4'd4, 1'b0, 1'b1); end
                default: begin ifW.i_load = 0; pushExp("mid_to5", 4'd5, 1'b0, 1'b1); end
            endcase
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_wrap: got {count,tc,ovf}=%b, expected 000000", got);
        end
        checks++;
        if (ifS.o_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_sat_ovf: got %b, expected 0", ifS.o_overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ifW.o_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got count=%0d, expected 0", ifW.o_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            pushExp($sformatf("resume j=%0d", j), 4'(j), 1'b0, 1'b0);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {ifW.o_count, ifW.o_tc, ifW.o_overflow};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         e.tag, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
            end
            @(negedge clk);
        end
        ifW.i_en = 0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_load_down();
        test_load_clamp();
        test_saturate();
        test_prescale();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_nbit_ctl.md
Name: counter_nbit_ctl

Overview:
Parametrised up/down counter, successor to the fixed 8-bit enable-only counter.
Adds configurable width and modulus, wrap or saturate mode, a clock-enable prescaler, synchronous clear/load, and terminal-count/overflow flags.
Used as the general counting primitive behind top-level pins and by timer/PWM blocks in the same design.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VALUE, 2**WIDTH-1, top of count range; counter spans 0..MAX_VALUE (must be < 2**WIDTH, >=1).
PRESCALE, 1, number of enabled cycles per count step (>=1; 1 = step every enabled cycle).
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_en  input  1  count enable; gates prescaler and stepping
i_clear  input  1  synchronous clear of count, prescaler, overflow flag
i_load  input  1  synchronous load of i_load_value
i_load_value  input  WIDTH  value to load
i_down  input  1  direction: 0 = up, 1 = down
i_ovf_clr  input  1  synchronous clear of o_overflow only
o_count  output  WIDTH  current count (registered)
o_at_limit  output  1  combinational: (o_count==MAX_VALUE && !i_down) || (o_count==0 && i_down)
o_tc  output  1  registered one-cycle terminal-count pulse
o_overflow  output  1  sticky flag: a wrap or saturation hit occurred

Behaviour:
- Reset (async, any time incl. mid-count): o_count=0, prescaler=0, o_tc=0, o_overflow=0; released synchronously on next edge after i_reset falls.
- Priority per edge: i_reset > i_clear > i_load > step. Lower-priority actions ignored in that cycle.
- i_clear: o_count<=0, prescaler<=0, o_overflow<=0, o_tc<=0.
- i_load: o_count<=min(i_load_value, MAX_VALUE); prescaler<=0; o_tc<=0; o_overflow unchanged (except by i_ovf_clr).
- Prescaler: internal counter pre 0..PRESCALE-1; advances only when i_en=1; holds when i_en=0. step = i_en && pre==PRESCALE-1; on step pre<=0. PRESCALE=1 -> step = i_en.
- Step, up: count<MAX_VALUE -> +1. count==MAX_VALUE -> wrap to 0 (SATURATE=0) or hold (SATURATE=1); limit event.
- Step, down: count>0 -> -1. count==0 -> wrap to MAX_VALUE (SATURATE=0) or hold (SATURATE=1); limit event.
- i_down sampled on the stepping edge; direction change mid-run takes effect on next step, no glitch.
- Limit event: o_tc<=1 for exactly one cycle (visible same cycle as the wrapped/held count); o_overflow<=1. In saturate mode every step attempted at the limit is a limit event.
- o_tc<=0 on every edge without a limit event.
- i_ovf_clr: o_overflow<=0, unless a limit event occurs same edge (set wins). i_clear always clears.
- Latency: count change visible one cycle after stepping edge; o_at_limit follows o_count and i_down combinationally.
- Arithmetic modulo per MAX_VALUE, never 2**WIDTH unless MAX_VALUE=2**WIDTH-1; o_count never exceeds MAX_VALUE.

Test Plan:
- WIDTH=4, MAX_VALUE=9, i_en=1, up from reset -> o_count 0..9, 0; o_tc high only in cycle o_count returns to 0; o_overflow stays 1.
- Same config, load 3, i_down=1 -> 2,1,0,9; o_tc pulse with 9; o_at_limit high while count=0.
- SATURATE=1, MAX_VALUE=9, up 12 cycles -> holds 9; o_tc high on each of 3 held steps; i_ovf_clr pulse -> o_overflow 0 unless concurrent limit.
- PRESCALE=3, i_en=1 for 9 cycles with i_en=0 for 2 cycles inserted -> o_count increments every 3rd enabled cycle, reaches 3; holds during i_en=0.
- i_load=1 with i_load_value=15 (MAX 9) -> o_count=9; i_clear and i_load same cycle -> o_count=0, o_overflow=0.
- Assert i_reset mid-count at 5 between edges -> o_count=0, o_tc=0, o_overflow=0 immediately; counting resumes from 0 after release.
